// File: rtl/base_vmem_tag_sched.sv
// base_vmem_tag_sched
//   Tag allocator/scheduler over a 2**a_width-entry in-use bit array. The tag
//   pool is shared among nreq requesters with round-robin arbitration. At most
//   one tag is granted per cycle. Tags come back on the free ports. Lookup
//   ports report in-use state one cycle after the request, and the reported
//   value already reflects the same-cycle grant and frees.
//
//   Optional feature macro: BASE_VMEM_TAG_SCHED_RSV_EN
//     Defined   : when o_free_cnt <= rsv, only requester 0 may be granted.
//     Undefined : every requester is eligible while any tag is free; rsv is
//                 ignored.
//
// Ports
//   clk         clock; all state changes on the rising edge
//   reset       asynchronous, active-high reset
//   i_req_v     request valid per requester (held until ready)
//   o_req_r     grant per requester (at most one bit set)
//   o_tag       tag granted this cycle
//   i_free_v    tag-return valid per free port
//   i_free_a    returned tags, packed per free port
//   i_rd_a      lookup tags, packed per lookup port
//   i_rd_en     lookup enable per lookup port
//   o_rd_d      in-use result, registered one cycle after i_rd_en
//   o_free_cnt  registered count of free tags
//   o_idle      registered; all tags free
//   o_err       sticky; a free named a tag that was not in use
module base_vmem_tag_sched #(
    parameter int unsigned a_width    = 4,
    parameter int unsigned nreq       = 2,
    parameter int unsigned free_ports = 1,
    parameter int unsigned rports     = 1,
    parameter int unsigned rsv        = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [nreq-1:0]               i_req_v,
    output logic [nreq-1:0]               o_req_r,
    output logic [a_width-1:0]            o_tag,
    input  logic [free_ports-1:0]         i_free_v,
    input  logic [free_ports*a_width-1:0] i_free_a,
    input  logic [rports*a_width-1:0]     i_rd_a,
    input  logic [rports-1:0]             i_rd_en,
    output logic [rports-1:0]             o_rd_d,
    output logic [a_width:0]              o_free_cnt,
    output logic                          o_idle,
    output logic                          o_err
);

    localparam int unsigned depth = 1 << a_width;
    localparam int unsigned ptr_w = (nreq > 1) ? $clog2(nreq) : 1;
    localparam logic [a_width:0] rsv_lim = (a_width + 1)'(rsv);

`ifdef BASE_VMEM_TAG_SCHED_RSV_EN
    localparam bit rsv_en = 1'b1;
`else
    localparam bit rsv_en = 1'b0;
`endif

    logic [depth-1:0]   in_use;
    logic [depth-1:0]   in_use_next;
    logic [depth-1:0]   alloc_dec;
    logic [depth-1:0]   free_dec;
    logic [ptr_w-1:0]   rr_ptr;
    logic [a_width-1:0] free_tag;
    logic               tag_found;
    logic               any_free;
    logic               rsv_only;
    logic [nreq-1:0]    eligible;
    logic [nreq-1:0]    grant;
    logic               req_found;
    int unsigned        idx;
    int unsigned        sel;
    logic               transfer;
    logic               err_hit;
    logic [a_width:0]   cnt_next;

    // Lowest-index free tag, from registered state only: a tag freed this
    // cycle is not offered until the next cycle.
    always_comb begin
        free_tag  = '0;
        tag_found = 1'b0;
        for (int unsigned k = 0; k < depth; k++) begin
            if (!tag_found && !in_use[k]) begin
                free_tag  = a_width'(k);
                tag_found = 1'b1;
            end
        end
    end

    assign any_free = (o_free_cnt != '0);
    assign rsv_only = rsv_en && (o_free_cnt <= rsv_lim);

    // Under reservation only requester 0 is eligible. Masking before the
    // round-robin search means skipped requesters never move the pointer.
    always_comb begin
        eligible = i_req_v;
        if (rsv_only) begin
            eligible    = '0;
            eligible[0] = i_req_v[0];
        end
    end

    always_comb begin
        grant     = '0;
        sel       = 0;
        idx       = 0;
        req_found = 1'b0;
        for (int unsigned i = 0; i < nreq; i++) begin
            idx = (32'(rr_ptr) + i) % nreq;
            if (!req_found && eligible[idx]) begin
                grant[idx] = 1'b1;
                sel        = idx;
                req_found  = 1'b1;
            end
        end
        if (!any_free || reset) begin
            grant = '0;
        end
    end

    assign o_req_r  = grant;
    assign o_tag    = free_tag;
    assign transfer = |grant;

    // Set/clear decode; a clear beats a set on the same tag, and duplicate
    // frees of one tag collapse into a single clear.
    always_comb begin
        alloc_dec = '0;
        if (transfer) begin
            alloc_dec[free_tag] = 1'b1;
        end
        free_dec = '0;
        err_hit  = 1'b0;
        for (int unsigned j = 0; j < free_ports; j++) begin
            if (i_free_v[j]) begin
                free_dec[i_free_a[j*a_width +: a_width]] = 1'b1;
                if (!in_use[i_free_a[j*a_width +: a_width]]) begin
                    err_hit = 1'b1;
                end
            end
        end
        in_use_next = (in_use | alloc_dec) & ~free_dec;
    end

    always_comb begin
        cnt_next = '0;
        for (int unsigned k = 0; k < depth; k++) begin
            cnt_next = cnt_next + (a_width + 1)'(!in_use_next[k]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_use     <= '0;
            rr_ptr     <= '0;
            o_free_cnt <= (a_width + 1)'(depth);
            o_idle     <= 1'b1;
            o_err      <= 1'b0;
        end else begin
            in_use     <= in_use_next;
            o_free_cnt <= cnt_next;
            o_idle     <= (in_use_next == '0);
            if (err_hit) begin
                o_err <= 1'b1;
            end
            if (transfer) begin
                rr_ptr <= ptr_w'((sel + 1) % nreq);
            end
        end
    end

    // Lookup reads in_use_next, which folds in the same-cycle alloc/free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_rd_d <= '0;
        end else begin
            for (int unsigned i = 0; i < rports; i++) begin
                if (i_rd_en[i]) begin
                    o_rd_d[i] <= in_use_next[i_rd_a[i*a_width +: a_width]];
                end
            end
        end
    end

endmodule

// File: tb/tb_base_vmem_tag_sched.sv
// Testbench for base_vmem_tag_sched (a_width=2, nreq=2, free_ports=1,
// rports=1, rsv=1). Stimulus pushes expected grants and expected status
// snapshots into queues; a monitor on the falling edge pops and compares.
module tb_base_vmem_tag_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] i_req_v;
    logic [1:0] o_req_r;
    logic [1:0] o_tag;
    logic [0:0] i_free_v;
    logic [1:0] i_free_a;
    logic [1:0] i_rd_a;
    logic [0:0] i_rd_en;
    logic [0:0] o_rd_d;
    logic [2:0] o_free_cnt;
    logic       o_idle;
    logic       o_err;

    always #5 clk = ~clk;

    base_vmem_tag_sched #(
        .a_width   (2),
        .nreq      (2),
        .free_ports(1),
        .rports    (1),
        .rsv       (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req_v   (i_req_v),
        .o_req_r   (o_req_r),
        .o_tag     (o_tag),
        .i_free_v  (i_free_v),
        .i_free_a  (i_free_a),
        .i_rd_a    (i_rd_a),
        .i_rd_en   (i_rd_en),
        .o_rd_d    (o_rd_d),
        .o_free_cnt(o_free_cnt),
        .o_idle    (o_idle),
        .o_err     (o_err)
    );

    typedef struct {
        logic [1:0] req_r;
        logic [1:0] tag;
        string      name;
    } gnt_t;

    typedef struct {
        int         cyc;
        bit         c_cnt;
        logic [2:0] cnt;
        bit         c_idle;
        logic       idle;
        bit         c_err;
        logic       err;
        bit         c_rd;
        logic       rd;
        bit         c_ng;
        string      name;
    } st_t;

    gnt_t gq[$];
    st_t  sq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_gnt(input logic [1:0] r, input logic [1:0] t, input string n);
        gnt_t g;
        g.req_r = r;
        g.tag   = t;
        g.name  = n;
        gq.push_back(g);
    endtask

    // -1 in any field means "not checked"; ng=1 checks that no grant is shown.
    task automatic exp_st(input string n, input int cnt, input int idle,
                          input int err, input int rd, input bit ng);
        st_t s;
        s.cyc    = cyc;
        s.c_cnt  = (cnt >= 0);
        s.cnt    = 3'(cnt);
        s.c_idle = (idle >= 0);
        s.idle   = 1'(idle);
        s.c_err  = (err >= 0);
        s.err    = 1'(err);
        s.c_rd   = (rd >= 0);
        s.rd     = 1'(rd);
        s.c_ng   = ng;
        s.name   = n;
        sq.push_back(s);
    endtask

    task automatic chk(input string n, input string f, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s: got %0d, expected %0d (cycle %0d)", n, f, act, req, cyc);
        end
    endtask

    initial begin
        st_t  s;
        gnt_t g;
        forever begin
            @(negedge clk);
            while (sq.size() > 0 && sq[0].cyc <= cyc) begin
                s = sq.pop_front();
                if (s.cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: snapshot missed, got cycle %0d, expected cycle %0d", s.name, cyc, s.cyc);
                end else begin
                    if (s.c_cnt)  chk(s.name, "o_free_cnt", int'(o_free_cnt), int'(s.cnt));
                    if (s.c_idle) chk(s.name, "o_idle", int'(o_idle), int'(s.idle));
                    if (s.c_err)  chk(s.name, "o_err", int'(o_err), int'(s.err));
                    if (s.c_rd)   chk(s.name, "o_rd_d", int'(o_rd_d), int'(s.rd));
                    if (s.c_ng)   chk(s.name, "o_req_r", int'(o_req_r), 0);
                end
            end
            if ((|o_req_r) === 1'b1) begin
                checks++;
                if (gq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant: got o_req_r=%b o_tag=%0d, expected no grant (cycle %0d)",
                             o_req_r, o_tag, cyc);
                end else begin
                    g = gq.pop_front();
                    if (o_req_r !== g.req_r || o_tag !== g.tag) begin
                        errors++;
                        $display("FAIL %s: got o_req_r=%b o_tag=%0d, expected o_req_r=%b o_tag=%0d (cycle %0d)",
                                 g.name, o_req_r, o_tag, g.req_r, g.tag, cyc);
                    end
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        i_req_v  = 2'b00;
        i_free_v = 1'b0;
        i_free_a = 2'd0;
        i_rd_a   = 2'd0;
        i_rd_en  = 1'b0;

        step();
        exp_st("rst_state", 4, 1, 0, 0, 1'b1);
        step();
        i_req_v = 2'b11;
        exp_st("rst_gate", 4, 1, 0, 0, 1'b1);
        step();
        i_req_v = 2'b00;
        reset   = 1'b0;
        exp_st("post_rst", 4, 1, 0, 0, 1'b1);

        // Round-robin fill of the whole pool.
        step();
        i_req_v = 2'b11;
        exp_gnt(2'b01, 2'd0, "t1_g0");
        exp_st("t1_c4", 4, 1, 0, -1, 1'b0);
        step();
        exp_gnt(2'b10, 2'd1, "t1_g1");
        exp_st("t1_c3", 3, 0, 0, -1, 1'b0);
        step();
        exp_gnt(2'b01, 2'd2, "t1_g2");
        exp_st("t1_c2", 2, 0, 0, -1, 1'b0);
        step();
        exp_gnt(2'b10, 2'd3, "t1_g3");
        exp_st("t1_c1", 1, 0, 0, -1, 1'b0);

        // Full pool; a freed tag is offered only from the following cycle.
        step();
        i_free_v = 1'b1;
        i_free_a = 2'd2;
        exp_st("t1_full", 0, 0, 0, -1, 1'b1);
        step();
        i_free_a = 2'd1;
        exp_gnt(2'b01, 2'd2, "t2_regrant");
        exp_st("t2_c1", 1, 0, 0, -1, 1'b0);
        step();
        i_free_v = 1'b0;
        i_rd_en  = 1'b1;
        i_rd_a   = 2'd3;
        exp_gnt(2'b10, 2'd1, "t2_freed_tag");
        exp_st("t2_c1b", 1, 0, 0, -1, 1'b0);

        // Lookup bypass with same-cycle free and same-cycle grant.
        step();
        i_rd_a   = 2'd1;
        i_free_v = 1'b1;
        i_free_a = 2'd1;
        exp_st("t3_rd_inuse", 0, 0, 0, 1, 1'b1);
        step();
        i_rd_en  = 1'b0;
        i_req_v  = 2'b00;
        i_free_a = 2'd0;
        exp_st("t3_rd_free", 1, 0, 0, 0, 1'b1);
        step();
        i_free_v = 1'b0;
        i_req_v  = 2'b11;
        i_rd_en  = 1'b1;
        i_rd_a   = 2'd0;
        exp_gnt(2'b01, 2'd0, "t3_g0");
        exp_st("t3_c2", 2, 0, 0, -1, 1'b0);
        step();
        i_rd_en = 1'b0;
        exp_gnt(2'b10, 2'd1, "t3_g1");
        exp_st("t3_rd_alloc", 1, 0, 0, 1, 1'b0);

        // Free of a tag already free raises a sticky error.
        step();
        i_req_v  = 2'b00;
        i_free_v = 1'b1;
        i_free_a = 2'd3;
        exp_st("t4_full", 0, 0, 0, 1, 1'b1);
        step();
        exp_st("t4_pre", 1, 0, 0, -1, 1'b1);
        step();
        i_free_v = 1'b0;
        exp_st("t4_err", 1, 0, 1, -1, 1'b1);
        step();
        exp_st("t4_sticky", 1, 0, 1, -1, 1'b1);

        // Reset mid-stream with three tags in use and requests pending.
        step();
        reset   = 1'b1;
        i_req_v = 2'b11;
        exp_st("t5_rst", 4, 1, 0, 0, 1'b1);
        step();
        reset   = 1'b0;
        i_req_v = 2'b01;
        exp_gnt(2'b01, 2'd0, "t5_first");
        exp_st("t5_after", 4, 1, 0, 0, 1'b0);
        step();
        i_req_v = 2'b10;
        exp_gnt(2'b10, 2'd1, "t6_g1");
        exp_st("t6_c3", 3, 0, 0, -1, 1'b0);
        step();
        i_req_v = 2'b01;
        exp_gnt(2'b01, 2'd2, "t6_g2");
        exp_st("t6_c2", 2, 0, 0, -1, 1'b0);
        step();
`ifdef BASE_VMEM_TAG_SCHED_RSV_EN
        i_req_v = 2'b10;
        exp_st("t6_rsv_block", 1, 0, 0, -1, 1'b1);
        step();
        i_req_v = 2'b11;
        exp_gnt(2'b01, 2'd3, "t6_rsv_req0");
        exp_st("t6_rsv_c1", 1, 0, 0, -1, 1'b0);
`else
        i_req_v = 2'b10;
        exp_gnt(2'b10, 2'd3, "t6_norsv_req1");
        exp_st("t6_norsv_c1", 1, 0, 0, -1, 1'b0);
`endif
        step();
        i_req_v = 2'b00;
        exp_st("end_full", 0, 0, 0, -1, 1'b1);
        step();
        step();

        checks++;
        if (gq.size() != 0) begin
            errors++;
            $display("FAIL grant_queue_drain: got %0d grants outstanding, expected 0", gq.size());
        end
        checks++;
        if (sq.size() != 0) begin
            errors++;
            $display("FAIL status_queue_drain: got %0d snapshots outstanding, expected 0", sq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
